// File: rtl/decode_dense_pipe_buf.sv
// Elastic in-order buffer between the decode stage and the dense stage.
// It replaces the fixed one-cycle register boundary with a valid/ready
// handshake and a depth-entry FIFO holding the complete decode bundle.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous discard of all buffered entries
//   in_valid / in_ready  decode-side handshake
//   act_type .. backprop_controll   incoming decode bundle fields
//   out_valid / out_ready           dense-side handshake
//   *_out                head-entry fields (valid only while out_valid)
//   count                number of occupied entries
module decode_dense_pipe_buf #(
  parameter int size                   = 3,
  parameter int data_size              = 16,
  parameter int cost_type_size         = 8,
  parameter int dense_type_size        = 4,
  parameter int act_type_size          = 4,
  parameter int backprop_controll_size = 100,
  parameter int depth                  = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [act_type_size-1:0]            act_type,
  input  logic [dense_type_size-1:0]          dense_type,
  input  logic [cost_type_size-1:0]           cost_type,
  input  logic [data_size*size-1:0]           w,
  input  logic                                load_w,
  input  logic [data_size*size-1:0]           x,
  input  logic [data_size*size-1:0]           label_in,
  input  logic [backprop_controll_size-1:0]   backprop_controll,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [act_type_size-1:0]            act_type_out,
  output logic [dense_type_size-1:0]          dense_type_out,
  output logic [cost_type_size-1:0]           cost_type_out,
  output logic [data_size*size-1:0]           w_out,
  output logic                                load_w_out,
  output logic [data_size*size-1:0]           x_out,
  output logic [data_size*size-1:0]           label_out,
  output logic [backprop_controll_size-1:0]   backprop_controll_out,
  output logic [$clog2(depth+1)-1:0]          count
);

  localparam int lane_w = data_size * size;
  localparam int bw     = act_type_size + dense_type_size + cost_type_size
                          + 3 * lane_w + 1 + backprop_controll_size;
  // A single-entry buffer still needs a 1-bit pointer to stay legal.
  localparam int ptr_w  = (depth > 1) ? $clog2(depth) : 1;
  localparam int cnt_w  = $clog2(depth + 1);
  localparam logic [ptr_w-1:0] ptr_last = ptr_w'(depth - 1);
  localparam logic [cnt_w-1:0] cnt_full = cnt_w'(depth);

  logic [bw-1:0]    mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [bw-1:0]    in_bundle;
  logic [bw-1:0]    head;
  logic             push;
  logic             pop;

  // Pointers wrap explicitly; depth need not be a power of two.
  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_last) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count < cnt_full) && !flush;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign in_bundle = {act_type, dense_type, cost_type, w, load_w, x,
                      label_in, backprop_controll};
  assign head      = mem[rd_ptr];
  assign {act_type_out, dense_type_out, cost_type_out, w_out, load_w_out,
          x_out, label_out, backprop_controll_out} = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Storage is left as-is; outputs are qualified by out_valid.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_bundle;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_dense_pipe_buf.sv
module tb_decode_dense_pipe_buf;

  localparam int BW = 4 + 4 + 8 + 48 + 1 + 48 + 48 + 100;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [3:0]    act_i;
  logic [3:0]    dense_i;
  logic [7:0]    cost_i;
  logic [47:0]   w_i;
  logic          lw_i;
  logic [47:0]   x_i;
  logic [47:0]   lab_i;
  logic [99:0]   bp_i;
  logic [BW-1:0] din;

  logic [2:0]    ir;
  logic [2:0]    ov;
  logic [2:0]    cntx [3];
  logic [BW-1:0] dout [3];

  int n_chk  = 0;
  int n_pass = 0;

  assign din = {act_i, dense_i, cost_i, w_i, lw_i, x_i, lab_i, bp_i};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three instances share one stimulus stream: depths 2, 3 and 5.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 2 : ((g == 1) ? 3 : 5);
    logic                   irdy;
    logic                   ovld;
    logic [3:0]             act_o;
    logic [3:0]             dense_o;
    logic [7:0]             cost_o;
    logic [47:0]            w_o;
    logic                   lw_o;
    logic [47:0]            x_o;
    logic [47:0]            lab_o;
    logic [99:0]            bp_o;
    logic [$clog2(D+1)-1:0] cnt;

    decode_dense_pipe_buf #(.depth(D)) u_dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .flush                 (flush),
      .in_valid              (in_valid),
      .in_ready              (irdy),
      .act_type              (act_i),
      .dense_type            (dense_i),
      .cost_type             (cost_i),
      .w                     (w_i),
      .load_w                (lw_i),
      .x                     (x_i),
      .label_in              (lab_i),
      .backprop_controll     (bp_i),
      .out_valid             (ovld),
      .out_ready             (out_ready),
      .act_type_out          (act_o),
      .dense_type_out        (dense_o),
      .cost_type_out         (cost_o),
      .w_out                 (w_o),
      .load_w_out            (lw_o),
      .x_out                 (x_o),
      .label_out             (lab_o),
      .backprop_controll_out (bp_o),
      .count                 (cnt)
    );

    assign ir[g]   = irdy;
    assign ov[g]   = ovld;
    assign cntx[g] = 3'(cnt);
    assign dout[g] = {act_o, dense_o, cost_o, w_o, lw_o, x_o, lab_o, bp_o};
  end

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic int dep(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 3 : 5);
  endfunction

  // Model: an unbounded FIFO per instance, kept as a history array with
  // monotonically increasing write/read sequence numbers.
  logic [BW-1:0] hist [3][256];
  int            wrn  [3];
  int            rdn  [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        wrn[k] = 0;
        rdn[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int occ;
        occ = wrn[k] - rdn[k];
        if (flush) begin
          rdn[k] = wrn[k];
        end else begin
          if (in_valid && occ < dep(k)) begin
            hist[k][wrn[k] % 256] = din;
            wrn[k]++;
          end
          if (out_ready && occ != 0) rdn[k]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        int occ;
        occ = wrn[k] - rdn[k];
        chk($sformatf("d%0d in_ready", k), BW'(ir[k]), BW'((occ < dep(k)) && !flush));
        chk($sformatf("d%0d out_valid", k), BW'(ov[k]), BW'(occ != 0));
        chk($sformatf("d%0d count", k), BW'(cntx[k]), BW'(occ));
        if (occ != 0) chk($sformatf("d%0d head", k), dout[k], hist[k][rdn[k] % 256]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mk(input int id);
    act_i   = 4'(id);
    dense_i = 4'(id + 1);
    cost_i  = 8'(id * 3);
    w_i     = {16'(id), 16'(id + 1), 16'(id + 2)};
    lw_i    = id[0];
    x_i     = {16'(id + 3), 16'(id + 4), 16'(id + 5)};
    lab_i   = {16'(id * 7), 16'(id + 11), 16'(id + 13)};
    bp_i    = '0;
    bp_i[99]   = id[0];
    bp_i[0]    = ~id[0];
    bp_i[40:9] = 32'(id);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && (cntx[0] | cntx[1] | cntx[2]) != 3'd0; i++) step();
    chk("drain", BW'(cntx[0] | cntx[1] | cntx[2]), BW'(0));
  endtask

  initial begin
    int accepted;
    logic acc;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mk(0);
    #3;
    chk("rst in_ready", BW'(ir[0]), BW'(1));
    chk("rst count", BW'(cntx[0]), BW'(0));
    chk("rst out", dout[0], BW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single transfer
    mk(0);
    act_i     = 4'h3;
    x_i       = 48'h0001_0002_0003;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single out_valid", BW'(ov[0]), BW'(1));
    chk("single x_out", BW'(g_dut[0].x_o), BW'(48'h0001_0002_0003));
    chk("single act_out", BW'(g_dut[0].act_o), BW'(4'h3));
    step();
    chk("single count after pop", BW'(cntx[0]), BW'(0));

    // Fill and back-pressure
    out_ready = 1'b0;
    mk(1); cost_i = 8'h11; in_valid = 1'b1;
    step();
    mk(2); cost_i = 8'h22;
    step();
    chk("full count", BW'(cntx[0]), BW'(2));
    chk("full in_ready", BW'(ir[0]), BW'(0));
    mk(3); cost_i = 8'h33;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold cost", BW'(g_dut[0].cost_o), BW'(8'h11));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("order B", BW'(g_dut[0].cost_o), BW'(8'h22));
    step();
    chk("C dropped", BW'(ov[0]), BW'(0));
    drain();

    // Streaming push+pop at count=1
    for (int i = 0; i < 10; i++) begin
      mk(100 + i);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      chk("stream count", BW'(cntx[1]), BW'(1));
    end
    in_valid = 1'b0;
    step();
    drain();

    // Flush
    out_ready = 1'b0;
    mk(200); in_valid = 1'b1;
    step();
    mk(201);
    step();
    chk("pre-flush count", BW'(cntx[0]), BW'(2));
    flush = 1'b1;
    mk(202);
    #1;
    chk("flush in_ready", BW'(ir[0]), BW'(0));
    step();
    flush = 1'b0;
    mk(203);
    chk("post-flush count", BW'(cntx[0]), BW'(0));
    chk("post-flush out_valid", BW'(ov[0]), BW'(0));
    step();
    in_valid = 1'b0;
    chk("post-flush push", BW'(g_dut[0].cost_o), BW'(8'h61));
    drain();

    // Wrap with random back-pressure
    void'($urandom(32'd7));
    accepted = 0;
    for (int i = 0; i < 200 && accepted < 12; i++) begin
      mk(300 + accepted);
      in_valid  = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      acc = ir[2];
      step();
      if (acc) accepted++;
    end
    in_valid = 1'b0;
    chk("wrap accepted", BW'(accepted), BW'(12));
    drain();

    // Asynchronous reset mid-run
    out_ready = 1'b0;
    mk(400); in_valid = 1'b1;
    step();
    mk(401);
    step();
    in_valid = 1'b0;
    chk("pre-reset count", BW'(cntx[0]), BW'(2));
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async d%0d count", k), BW'(cntx[k]), BW'(0));
      chk($sformatf("async d%0d out_valid", k), BW'(ov[k]), BW'(0));
      chk($sformatf("async d%0d in_ready", k), BW'(ir[k]), BW'(1));
    end
    chk("async act_out", BW'(g_dut[0].act_o), BW'(0));
    chk("async w_out", BW'(g_dut[0].w_o), BW'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decode_dense_pipe_buf.md
Name: decode_dense_pipe_buf

Overview:
Elastic, parametrised pipeline buffer between the decode stage and the dense stage. It replaces the fixed one-cycle register boundary with a valid/ready handshake and a DEPTH-entry in-order buffer. It carries the complete decode bundle: activation, dense and cost type codes, weights, load_w, input x, label and backprop control. It adds back-pressure, a synchronous flush and an occupancy count, so dense-stage stalls no longer drop or overwrite decoded words.

Parameters:
size, 3, number of data lanes in w, x and label
data_size, 16, bits per lane
cost_type_size, 8, cost type code width
dense_type_size, 4, dense type code width
act_type_size, 4, activation type code width
backprop_controll_size, 100, backprop control word width (32*3+4)
depth, 2, number of buffer entries; legal range is 1 or more, any integer

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous discard of all buffered entries
in_valid  in  1  decode side presents a bundle
in_ready  out  1  buffer accepts the bundle this cycle
act_type  in  act_type_size  activation code
dense_type  in  dense_type_size  dense code
cost_type  in  cost_type_size  cost code
w  in  data_size*size  weights, lane 0 in the LSBs
load_w  in  1  weight-load strobe
x  in  data_size*size  input vector
label_in  in  data_size*size  label vector
backprop_controll  in  backprop_controll_size  backprop control word
out_valid  out  1  head entry is presented
out_ready  in  1  dense side consumes the head entry
act_type_out, dense_type_out, cost_type_out, w_out, load_w_out, x_out, label_out, backprop_controll_out  out  widths match the corresponding inputs  head-entry fields
count  out  $clog2(depth+1)  number of occupied entries

Behaviour:
- Reset: rst_n low clears state asynchronously. count=0, read and write pointers=0, out_valid=0, all storage entries=0. As a result every *_out field reads 0 and in_ready=1. Reset deasserts synchronously to clk as seen by the logic.
- Push: occurs when in_valid && in_ready. The whole bundle is written to the write pointer entry and the pointer advances.
- Pop: occurs when out_valid && out_ready. The read pointer advances.
- Pointers wrap from depth-1 to 0. The buffer is not restricted to power-of-two depth, so there is no implicit modulo.
- in_ready = (count < depth) && !flush. This is combinational from registered count and flush. in_ready does not depend on out_ready, so there is no full-buffer pass-through.
- out_valid = (count != 0). The *_out fields are the storage entry at the read pointer. The path from storage to output is mux-only, with no arithmetic.
- Latency: a bundle pushed at edge N is visible on the outputs after edge N. Its earliest pop is the following cycle, so minimum latency is 1 cycle, matching the old register boundary. There is no combinational in-to-out path.
- Ordering: strict FIFO. Fields from different pushes are never mixed.
- Stability: while out_valid && !out_ready, every *_out field and out_valid hold unchanged.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged. This is legal whenever 0 < count < depth.
  - neither: unchanged
- count=0 with in_valid: push occurs, and out_valid rises the next cycle, never the same cycle.
- count=depth: in_ready=0 and in_valid is ignored. A pop that cycle frees a slot, but it becomes visible to in_ready only next cycle.
- Flush has the highest priority after reset. At the edge it sets count=0 and both pointers=0.
  - The cycle's push is blocked, because in_ready=0.
  - A head entry handshaken in the flush cycle counts as consumed. All remaining entries are discarded.
  - Storage contents need not be cleared, but outputs are qualified only by out_valid.
- load_w is carried as ordinary data. It is not interpreted, latched or combined across entries.
- Illegal conditions (overflow, underflow) cannot occur. Writes without in_ready and pops without out_valid have no effect.
- depth=1: behaves as a half-throughput register. A push and a pop can never coincide because in_ready=0 when full.

Test Plan:
1. Reset: assert rst_n=0 mid-run with count=2 -> immediately count=0, out_valid=0, in_ready=1, act_type_out=0, w_out=0; no clk edge is required.
2. Single transfer, depth=2, out_ready=1: push act_type=4'h3, x=48'h0001_0002_0003 at edge 0 -> out_valid=1 after edge 0 with x_out=48'h0001_0002_0003. The pop at edge 1 gives count=0.
3. Fill and back-pressure, depth=2, out_ready=0: push A (cost_type=8'h11) then B (8'h22) -> count=2, in_ready=0, and a third push of C is ignored. Hold for 5 cycles -> cost_type_out=8'h11 stays stable. Then set out_ready=1 -> A and B emerge in order and C is never seen.
4. Simultaneous push/pop at count=1, depth=3: stream 10 bundles with in_valid=out_ready=1 -> count stays at 1 and the outputs appear in order with 1-cycle spacing. The backprop_controll bit-99/bit-0 patterns are preserved.
5. Flush: with count=2 and in_valid=1, assert flush for one cycle -> in_ready=0 that cycle, count=0 after the edge and out_valid=0; the flushed push never appears. The next push appears normally.
6. depth=5 wrap: push and pop 12 entries with randomized out_ready (seeded) -> the pointers wrap past index 4 correctly and all 12 label_out values match input order.
